// File: rtl/cnet_prog_pkg.sv
// Shared types and constants for the CNET SelectMAP configuration controller.
package cnet_prog_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PROG_LOW  = 3'd1,
        WAIT_INIT = 3'd2,
        WRITE     = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CRC     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_LEN     = 2'd3;

endpackage

// File: rtl/cnet_cclk_gen.sv
// Free-running configuration clock with a strobe marking the cycle in which it falls.
module cnet_cclk_gen #(
    parameter int unsigned CCLK_HALF = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic rp_cclk,
    output logic fall_c
);

    localparam int unsigned CNT_W = (CCLK_HALF > 1) ? $clog2(CCLK_HALF) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             wrap_c;

    assign wrap_c = (cnt_q == CNT_W'(CCLK_HALF - 1));
    assign fall_c = wrap_c && rp_cclk;

    // Half-period counter; rp_cclk toggles on each wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            rp_cclk <= 1'b0;
        end else if (wrap_c) begin
            cnt_q   <= '0;
            rp_cclk <= ~rp_cclk;
        end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cnet_prog_ctrl.sv
// SelectMAP write-only configuration sequencer for the CNET FPGA.
// Optional macro CNET_PROG_TIMEOUT_EN bounds WAIT_INIT/WAIT_DONE to TIMEOUT_CYC cclk periods.
module cnet_prog_ctrl
    import cnet_prog_pkg::*;
#(
    parameter int unsigned CCLK_HALF    = 2,
    parameter int unsigned PROG_LOW_CYC = 12,
    parameter int unsigned TIMEOUT_CYC  = 4096,
    parameter int unsigned LEN_W        = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             prog_start,
    input  logic [LEN_W-1:0] prog_len,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_rd,
    output logic             rp_prog_b,
    input  logic             rp_init_b,
    output logic             rp_cs_b,
    output logic             rp_rdwr_b,
    output logic [7:0]       rp_data,
    input  logic             rp_done,
    output logic             rp_cclk,
    output logic             busy,
    output logic             prog_ok,
    output logic             prog_err,
    output logic [1:0]       err_code
);

    localparam int unsigned PL_W = (PROG_LOW_CYC > 1) ? $clog2(PROG_LOW_CYC) : 1;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [PL_W-1:0]  plow_q, plow_d;
    logic             pend_q, pend_d;
    logic             busy_d, prog_b_d, cs_b_d, din_rd_d, ok_d, err_d;
    logic [7:0]       data_d;
    logic [1:0]       code_d;
    logic [1:0]       init_sync_q, done_sync_q;
    logic             init_s, done_s, fall_c, tmo_hit_c;

    assign rp_rdwr_b = 1'b0;
    assign init_s    = init_sync_q[1];
    assign done_s    = done_sync_q[1];

    cnet_cclk_gen #(
        .CCLK_HALF (CCLK_HALF)
    ) u_cclk (
        .clk     (clk),
        .reset_n (reset_n),
        .rp_cclk (rp_cclk),
        .fall_c  (fall_c)
    );

    // Two-flop synchronisers for the CNET status pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_sync_q <= '0;
            done_sync_q <= '0;
        end else begin
            init_sync_q <= {init_sync_q[0], rp_init_b};
            done_sync_q <= {done_sync_q[0], rp_done};
        end
    end

`ifdef CNET_PROG_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    // Counts fall strobes spent in the current wait state; cleared on every state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if ((state_d != state_q) ||
                     !((state_q == WAIT_INIT) || (state_q == WAIT_DONE))) begin
            tmo_q <= '0;
        end else if (fall_c) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    // Waits are unbounded; the parameter is kept so both builds share one interface.
    localparam int unsigned timeout_cyc_unused = TIMEOUT_CYC;

    assign tmo_hit_c = 1'b0;
`endif

    // Next-state and next-output decode; sequencing advances only on a cclk fall strobe.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        plow_d   = plow_q;
        pend_d   = pend_q;
        busy_d   = busy;
        prog_b_d = rp_prog_b;
        cs_b_d   = rp_cs_b;
        data_d   = rp_data;
        code_d   = err_code;
        din_rd_d = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;

        // Start is accepted on any clk; the sequence itself begins at the next strobe.
        if (prog_start && !busy && !pend_q) begin
            rem_d  = prog_len;
            code_d = ERR_NONE;
            pend_d = 1'b1;
            busy_d = (prog_len != '0);
        end

        if (fall_c) begin
            case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        pend_d = 1'b0;
                        if (rem_q == '0) begin
                            err_d  = 1'b1;
                            code_d = ERR_LEN;
                        end else begin
                            state_d  = PROG_LOW;
                            prog_b_d = 1'b0;
                            plow_d   = PL_W'(PROG_LOW_CYC - 1);
                        end
                    end
                end
                PROG_LOW: begin
                    if (plow_q == '0) begin
                        prog_b_d = 1'b1;
                        state_d  = WAIT_INIT;
                    end else begin
                        plow_d = plow_q - PL_W'(1);
                    end
                end
                WAIT_INIT: begin
                    if (init_s) begin
                        state_d = WRITE;
                    end else if (tmo_hit_c) begin
                        cs_b_d  = 1'b1;
                        err_d   = 1'b1;
                        code_d  = ERR_TIMEOUT;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                WRITE: begin
                    if (!init_s) begin
                        cs_b_d  = 1'b1;
                        err_d   = 1'b1;
                        code_d  = ERR_CRC;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (rem_q == '0) begin
                        cs_b_d  = 1'b1;
                        state_d = WAIT_DONE;
                    end else if (din_valid) begin
                        data_d   = din;
                        cs_b_d   = 1'b0;
                        din_rd_d = 1'b1;
                        rem_d    = rem_q - LEN_W'(1);
                    end else begin
                        cs_b_d = 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!init_s) begin
                        cs_b_d  = 1'b1;
                        err_d   = 1'b1;
                        code_d  = ERR_CRC;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (done_s) begin
                        ok_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (tmo_hit_c) begin
                        cs_b_d  = 1'b1;
                        err_d   = 1'b1;
                        code_d  = ERR_TIMEOUT;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            plow_q    <= '0;
            pend_q    <= 1'b0;
            busy      <= 1'b0;
            rp_prog_b <= 1'b1;
            rp_cs_b   <= 1'b1;
            rp_data   <= '0;
            din_rd    <= 1'b0;
            prog_ok   <= 1'b0;
            prog_err  <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            plow_q    <= plow_d;
            pend_q    <= pend_d;
            busy      <= busy_d;
            rp_prog_b <= prog_b_d;
            rp_cs_b   <= cs_b_d;
            rp_data   <= data_d;
            din_rd    <= din_rd_d;
            prog_ok   <= ok_d;
            prog_err  <= err_d;
            err_code  <= code_d;
        end
    end

endmodule

// File: tb/tb_cnet_prog_ctrl.sv
// Scoreboard bench for cnet_prog_ctrl with a byte FIFO source and a CNET pin emulator.
module tb_cnet_prog_ctrl;

    localparam int unsigned CCLK_HALF    = 2;
    localparam int unsigned PROG_LOW_CYC = 12;
    localparam int unsigned TIMEOUT_CYC  = 64;
    localparam int unsigned LEN_W        = 24;

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic             prog_start = 1'b0;
    logic [LEN_W-1:0] prog_len   = '0;
    logic [7:0]       din        = '0;
    logic             din_valid  = 1'b0;
    logic             rp_init_b  = 1'b1;
    logic             rp_done    = 1'b0;
    logic             din_rd, rp_prog_b, rp_cs_b, rp_rdwr_b, rp_cclk;
    logic             busy, prog_ok, prog_err;
    logic [7:0]       rp_data;
    logic [1:0]       err_code;

    cnet_prog_ctrl #(
        .CCLK_HALF    (CCLK_HALF),
        .PROG_LOW_CYC (PROG_LOW_CYC),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .LEN_W        (LEN_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .prog_start (prog_start),
        .prog_len   (prog_len),
        .din        (din),
        .din_valid  (din_valid),
        .din_rd     (din_rd),
        .rp_prog_b  (rp_prog_b),
        .rp_init_b  (rp_init_b),
        .rp_cs_b    (rp_cs_b),
        .rp_rdwr_b  (rp_rdwr_b),
        .rp_data    (rp_data),
        .rp_done    (rp_done),
        .rp_cclk    (rp_cclk),
        .busy       (busy),
        .prog_ok    (prog_ok),
        .prog_err   (prog_err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_bad = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_bytes[$];
    logic [3:0] exp_res[$];
    int         rd_cnt = 0, low_cnt = 0, cap_cnt = 0, res_cnt = 0, pop_cnt = 0;
    int         stall_left = 0, crc_k = 0, job_len = 0, init_dly = 0;
    bit         stall5 = 0, rand_stall_en = 0, force_init_low = 0, cclk_prev = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".prog_b"}, rp_prog_b, 1);
        check({tag, ".cs_b"}, rp_cs_b, 1);
        check({tag, ".rdwr_b"}, rp_rdwr_b, 0);
        check({tag, ".data"}, rp_data, 0);
        check({tag, ".cclk"}, rp_cclk, 0);
        check({tag, ".din_rd"}, din_rd, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".prog_ok"}, prog_ok, 0);
        check({tag, ".prog_err"}, prog_err, 0);
        check({tag, ".err_code"}, err_code, 0);
    endtask

    // FIFO pop: a byte leaves when din_rd and din_valid are both high at a clk edge.
    always @(posedge clk) begin
        if (din_rd && din_valid && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pop_cnt++;
            if (stall5 && pop_cnt == 5) stall_left = 4 * CCLK_HALF * 3;
        end
    end

    // FIFO head presentation; valid only changes while no pop is pending.
    always @(negedge clk) begin
        if (!din_rd) begin
            if (stall_left > 0) stall_left--;
            else if (rand_stall_en && $urandom_range(0, 7) == 0) stall_left = $urandom_range(1, 10);
            din_valid = (fifo_q.size() > 0) && (stall_left == 0);
            din       = din_valid ? fifo_q[0] : 8'h00;
        end
    end

    // Output monitor plus CNET pin emulator, sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] eb;
        logic [3:0] er;
        bit         rise;
        rise      = rp_cclk && !cclk_prev;
        cclk_prev = rp_cclk;
        if (reset_n) begin
            if (rise && !rp_prog_b) low_cnt++;
            if (rise && !rp_cs_b) begin
                cap_cnt++;
                check("byte_pending", int'(exp_bytes.size() > 0), 1);
                if (exp_bytes.size() > 0) begin
                    eb = exp_bytes.pop_front();
                    check("cnet_byte", rp_data, eb);
                end
            end
            if (din_rd) rd_cnt++;
            if (prog_ok || prog_err) begin
                res_cnt++;
                check("result_pending", int'(exp_res.size() > 0), 1);
                if (exp_res.size() > 0) begin
                    er = exp_res.pop_front();
                    check("result", {prog_ok, prog_err, err_code}, er);
                    check("busy_at_result", busy, 0);
                    check("rdwr_b", rp_rdwr_b, 0);
                end
            end
            if (!rp_prog_b) begin
                rp_init_b = 1'b0;
                rp_done   = 1'b0;
                init_dly  = 6;
            end else if (force_init_low) begin
                rp_init_b = 1'b0;
            end else if (init_dly > 0) begin
                init_dly--;
                if (init_dly == 0) rp_init_b = 1'b1;
            end
            if (din_rd && crc_k > 0 && rd_cnt == crc_k) rp_init_b = 1'b0;
            if (crc_k == 0 && job_len > 0 && cap_cnt == job_len) rp_done = 1'b1;
        end
    end

    task automatic run_job(input int len, input int k_crc, input bit st5, input bit rstall,
                           input bit ign, input int rst_at, input bit tmo);
        int         consumed, d0;
        bit         got, ign_done;
        logic [3:0] er;
        fifo_q.delete();
        exp_bytes.delete();
        for (int i = 0; i < len; i++) fifo_q.push_back(8'($urandom));
        if (len == 0 || tmo) consumed = 0;
        else if (k_crc > 0) consumed = k_crc;
        else consumed = len;
        for (int i = 0; i < consumed; i++) exp_bytes.push_back(fifo_q[i]);
        if (len == 0) er = 4'b0111;
        else if (tmo) er = 4'b0110;
        else if (k_crc > 0) er = 4'b0101;
        else er = 4'b1000;
        if (rst_at == 0) exp_res.push_back(er);
        crc_k = k_crc; stall5 = st5; rand_stall_en = rstall; force_init_low = tmo;
        job_len = len; rd_cnt = 0; low_cnt = 0; cap_cnt = 0; pop_cnt = 0;
        d0 = res_cnt; got = 0; ign_done = 0;
        @(negedge clk);
        prog_len = LEN_W'(len); prog_start = 1'b1;
        @(negedge clk);
        prog_start = 1'b0; prog_len = LEN_W'($urandom);
        for (int c = 0; c < 8000; c++) begin
            if (res_cnt != d0) begin got = 1; break; end
            if (ign && !ign_done && rd_cnt == 2) begin
                ign_done = 1; prog_len = LEN_W'(3); prog_start = 1'b1;
                @(negedge clk);
                prog_start = 1'b0;
            end
            if (rst_at > 0 && rd_cnt >= rst_at) begin
                reset_n = 1'b0;
                #1;
                check_reset_outputs("mid_reset");
                repeat (4) begin
                    @(negedge clk);
                    check("din_rd_in_reset", din_rd, 0);
                end
                reset_n = 1'b1;
                exp_bytes.delete();
                exp_res.delete();
                repeat (20) @(negedge clk);
                check("no_pop_after_reset", rd_cnt, rst_at);
                check("busy_after_reset", busy, 0);
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check("job_finished", got, 1);
        if (rst_at == 0) begin
            repeat (3) @(negedge clk);
            check("din_rd_pulses", rd_cnt, consumed);
            check("prog_b_low_periods", low_cnt, (len == 0) ? 0 : PROG_LOW_CYC);
            check("bytes_unwritten", exp_bytes.size(), 0);
            check("fifo_left", fifo_q.size(), len - consumed);
            check("err_code_held", err_code, er[1:0]);
            check("busy_idle", busy, 0);
            check("cs_b_idle", rp_cs_b, 1);
            check("prog_b_idle", rp_prog_b, 1);
        end
        rand_stall_en = 0; stall5 = 0; stall_left = 0; force_init_low = 0; crc_k = 0;
        fifo_q.delete();
        exp_res.delete();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        run_job(16, 0, 0, 0, 0, 0, 0);   // nominal
        run_job(16, 0, 1, 0, 1, 0, 0);   // stall after byte 5, start ignored while busy
        run_job(16, 1, 0, 0, 0, 0, 0);   // init_b falls after first byte
        run_job(0, 0, 0, 0, 0, 0, 0);    // zero length
        run_job(16, 0, 0, 0, 0, 8, 0);   // reset during byte 8
        run_job(7, 0, 0, 0, 0, 0, 0);    // recovery after reset
        for (int j = 0; j < 6; j++) begin
            int len, k;
            len = $urandom_range(1, 40);
            k   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
            run_job(len, k, 0, 1, 0, 0, 0);
        end
`ifdef CNET_PROG_TIMEOUT_EN
        run_job(5, 0, 0, 0, 0, 0, 1);    // init_b stuck low
`endif
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

endmodule
